// File: rtl/wb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_sram_arbiter
//
// Two-master to one-slave Wishbone classic arbiter. It shares one SRAM slave
// between the instruction-fetch port (master 0) and the load/store port
// (master 1). Ownership is granted for a whole bus cycle: once a master owns
// the slave it keeps it for as long as it holds cyc. The owner's signals are
// multiplexed onto the slave port, and ack is returned to the owner only.
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN  defined    -> a tie goes to the master that was
//                                        not granted most recently.
//                          undefined  -> fixed priority: master 0 wins ties.
//
// Parameters:
//   addr_width    address width of all ports
//   data_width    data width of all ports
//   strobe_width  byte-select width (data_width/8)
//
// Ports:
//   clock, reset                  system clock (rising edge) and synchronous
//                                 active-high reset
//   m0_wb_* / m1_wb_*             Wishbone master-side ports
//                                 (adr, datwr, we, stb, cyc, sel in;
//                                  datrd, ack out)
//   s_wb_*                        Wishbone slave-side port
//                                 (adr, datwr, we, stb, cyc, sel out;
//                                  datrd, ack in)
//   grant                         one-hot current owner: 01 = m0, 10 = m1,
//                                 00 = idle
// -----------------------------------------------------------------------------
module wb_sram_arbiter #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8
) (
  input  logic                    clock,
  input  logic                    reset,

  // Master 0 (instruction fetch)
  input  logic [addr_width-1:0]   m0_wb_adr,
  input  logic [data_width-1:0]   m0_wb_datwr,
  output logic [data_width-1:0]   m0_wb_datrd,
  input  logic                    m0_wb_we,
  input  logic                    m0_wb_stb,
  input  logic                    m0_wb_cyc,
  input  logic [strobe_width-1:0] m0_wb_sel,
  output logic                    m0_wb_ack,

  // Master 1 (load/store)
  input  logic [addr_width-1:0]   m1_wb_adr,
  input  logic [data_width-1:0]   m1_wb_datwr,
  output logic [data_width-1:0]   m1_wb_datrd,
  input  logic                    m1_wb_we,
  input  logic                    m1_wb_stb,
  input  logic                    m1_wb_cyc,
  input  logic [strobe_width-1:0] m1_wb_sel,
  output logic                    m1_wb_ack,

  // Slave
  output logic [addr_width-1:0]   s_wb_adr,
  output logic [data_width-1:0]   s_wb_datwr,
  input  logic [data_width-1:0]   s_wb_datrd,
  output logic                    s_wb_we,
  output logic                    s_wb_stb,
  output logic                    s_wb_cyc,
  output logic [strobe_width-1:0] s_wb_sel,
  input  logic                    s_wb_ack,

  // Observation
  output logic [1:0]              grant
);

  // State encoding equals the one-hot grant value, so grant is the state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  state_e tie_winner;

  // Most recently entered grant state: 0 = master 0, 1 = master 1.
  logic   last_grant_q, last_grant_d;

  // ---------------------------------------------------------------------------
  // Tie resolution
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_ROUND_ROBIN_EN
  // Favour the master that did not win last time; after reset last_grant_q
  // is 1, so master 0 takes the first tie.
  assign tie_winner = last_grant_q ? ST_GRANT0 : ST_GRANT1;
`else
  assign tie_winner = ST_GRANT0;
`endif

  // Winner among the given requests; callers mask the releasing owner's
  // request so the other master is granted without passing through IDLE.
  function automatic state_e arbitrate(input logic   req0,
                                       input logic   req1,
                                       input state_e tie);
    state_e winner;
    unique case ({req1, req0})
      2'b01:   winner = ST_GRANT0;
      2'b10:   winner = ST_GRANT1;
      2'b11:   winner = tie;
      default: winner = ST_IDLE;
    endcase
    return winner;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, so it is tested inside the clocked block, not in the
  // sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = arbitrate(m0_wb_cyc, m1_wb_cyc, tie_winner);
      // The owner is never preempted while it holds cyc.
      ST_GRANT0: if (!m0_wb_cyc) state_d = arbitrate(1'b0, m1_wb_cyc, tie_winner);
      ST_GRANT1: if (!m1_wb_cyc) state_d = arbitrate(m0_wb_cyc, 1'b0, tie_winner);
      default:   state_d = ST_IDLE;
    endcase
  end

  // Record the grant on every entry into a grant state.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_d == ST_GRANT0 && state_q != ST_GRANT0) begin
      last_grant_d = 1'b0;
    end else if (state_d == ST_GRANT1 && state_q != ST_GRANT1) begin
      last_grant_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: slave mux and ack return, decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    s_wb_adr   = '0;
    s_wb_datwr = '0;
    s_wb_we    = 1'b0;
    s_wb_stb   = 1'b0;
    s_wb_cyc   = 1'b0;
    s_wb_sel   = '0;
    m0_wb_ack  = 1'b0;
    m1_wb_ack  = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        s_wb_adr   = m0_wb_adr;
        s_wb_datwr = m0_wb_datwr;
        s_wb_we    = m0_wb_we;
        s_wb_stb   = m0_wb_stb;
        s_wb_cyc   = m0_wb_cyc;
        s_wb_sel   = m0_wb_sel;
        m0_wb_ack  = s_wb_ack;
      end
      ST_GRANT1: begin
        s_wb_adr   = m1_wb_adr;
        s_wb_datwr = m1_wb_datwr;
        s_wb_we    = m1_wb_we;
        s_wb_stb   = m1_wb_stb;
        s_wb_cyc   = m1_wb_cyc;
        s_wb_sel   = m1_wb_sel;
        m1_wb_ack  = s_wb_ack;
      end
      // In IDLE the slave port is quiet and a stray slave ack reaches no one.
      default: ;
    endcase
  end

  // Read data is broadcast; each master only takes it while its ack is high.
  assign m0_wb_datrd = s_wb_datrd;
  assign m1_wb_datrd = s_wb_datrd;

  assign grant = state_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clock) $onehot0(grant));

  a_ack_exclusive : assert property (@(posedge clock) !(m0_wb_ack && m1_wb_ack));

  // While a master owns the slave it is also the recorded last grant.
  a_last_grant_consistent : assert property (
    @(posedge clock) disable iff (reset)
      ((state_q == ST_GRANT0) |-> !last_grant_q) and
      ((state_q == ST_GRANT1) |->  last_grant_q));
`endif

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for wb_sram_arbiter.
// A cycle-by-cycle vector table drives both masters and a hand-driven slave
// ack; afterwards a small SRAM model (ack one cycle after stb) replaces the
// hand-driven ack for multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_wb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  localparam logic [AW-1:0] T_ADR0 = 32'h0000_0100;
  localparam logic [AW-1:0] T_ADR1 = 32'h0000_0200;
  localparam logic [DW-1:0] T_DAT0 = 32'hA0A0_A0A0;
  localparam logic [DW-1:0] T_DAT1 = 32'hB1B1_B1B1;
  localparam logic [SW-1:0] T_SEL0 = 4'h3;
  localparam logic [SW-1:0] T_SEL1 = 4'hC;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];

  logic [DW-1:0] m0_datrd, m1_datrd;
  logic          m0_ack, m1_ack;
  logic [1:0]    acks;

  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_datwr, s_datrd;
  logic          s_we, s_stb, s_cyc, s_ack;
  logic [SW-1:0] s_sel;
  logic [1:0]    grant;

  logic use_model = 1'b0;
  logic tbl_ack   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  wb_sram_arbiter #(.addr_width(AW), .data_width(DW), .strobe_width(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0_wb_adr   (m_adr[0]),
    .m0_wb_datwr (m_dat[0]),
    .m0_wb_datrd (m0_datrd),
    .m0_wb_we    (m_we[0]),
    .m0_wb_stb   (m_stb[0]),
    .m0_wb_cyc   (m_cyc[0]),
    .m0_wb_sel   (m_sel[0]),
    .m0_wb_ack   (m0_ack),
    .m1_wb_adr   (m_adr[1]),
    .m1_wb_datwr (m_dat[1]),
    .m1_wb_datrd (m1_datrd),
    .m1_wb_we    (m_we[1]),
    .m1_wb_stb   (m_stb[1]),
    .m1_wb_cyc   (m_cyc[1]),
    .m1_wb_sel   (m_sel[1]),
    .m1_wb_ack   (m1_ack),
    .s_wb_adr    (s_adr),
    .s_wb_datwr  (s_datwr),
    .s_wb_datrd  (s_datrd),
    .s_wb_we     (s_we),
    .s_wb_stb    (s_stb),
    .s_wb_cyc    (s_cyc),
    .s_wb_sel    (s_sel),
    .s_wb_ack    (s_ack),
    .grant       (grant)
  );

  assign acks = {m1_ack, m0_ack};

  // ---------------------------------------------------------------------------
  // SRAM slave model: ack one cycle after stb, registered read data.
  // It ignores the arbiter reset so an in-flight ack can arrive during IDLE.
  // ---------------------------------------------------------------------------
  logic          mdl_ack   = 1'b0;
  logic [DW-1:0] mdl_rdata = '0;
  logic [DW-1:0] mem [64];

  always @(posedge clock) begin
    if (s_cyc && s_stb && !mdl_ack) begin
      mdl_ack <= 1'b1;
      if (s_we) begin
        for (int b = 0; b < SW; b++)
          if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_datwr[8*b +: 8];
      end else begin
        mdl_rdata <= mem[s_adr[7:2]];
      end
    end else begin
      mdl_ack <= 1'b0;
    end
  end

  assign s_ack   = use_model ? mdl_ack : tbl_ack;
  assign s_datrd = mdl_rdata;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] own(input int mi);
    return (mi == 0) ? 2'b01 : 2'b10;
  endfunction

  // One isolated access from IDLE; checks grant/address in cycle 1 and that
  // the ack arrives to the owner in cycle 2 and never to the other master.
  task automatic single_access(input int mi, input logic we, input logic [AW-1:0] adr,
                               input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                               output logic [DW-1:0] rdata);
    int k;
    rdata = '0;
    m_cyc[mi] = 1'b1; m_stb[mi] = 1'b1; m_we[mi] = we;
    m_adr[mi] = adr;  m_dat[mi] = dat;  m_sel[mi] = sel;
    for (k = 0; k < 10; k++) begin
      #1;
      if (k == 1) begin
        check("single_grant", 32'(grant), 32'(own(mi)));
        check("single_s_adr", s_adr, adr);
      end
      check("single_other_ack", 32'(acks[1-mi]), 32'd0);
      if (acks[mi]) begin
        rdata = (mi == 0) ? m0_datrd : m1_datrd;
        break;
      end
      @(negedge clock);
    end
    check("single_ack_cycle", 32'(k), 32'd2);
    @(negedge clock);
    m_cyc[mi] = 1'b0; m_stb[mi] = 1'b0; m_we[mi] = 1'b0;
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs for one cycle and the outputs expected in that cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst, c0, s0, c1, s1, sack;
    logic [1:0] g;
    logic       scyc, sstb, a0, a1;
  } vec_t;

  vec_t vt [18];

  initial begin
    #100000;
    $display("FAIL watchdog: summary not reached in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] burst_exp [3];
    logic [1:0]    exp_tie [4];
    logic [1:0]    glog [$];
    logic [1:0]    prev_g;
    int            cnt [2];
    logic [1:0]    drop;
    int            idx;
    int            k;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic          e_we;

    //        rst c0 s0 c1 s1 sack   grant  scyc sstb a0 a1
    vt[0]  = '{1, 1, 1, 1, 1, 0,    2'b00, 0,   0,   0, 0}; // reset, both request
    vt[1]  = '{1, 1, 1, 1, 1, 0,    2'b00, 0,   0,   0, 0};
    vt[2]  = '{0, 1, 1, 1, 1, 0,    2'b00, 0,   0,   0, 0}; // released, still idle
    vt[3]  = '{0, 1, 1, 1, 1, 1,    2'b01, 1,   1,   1, 0}; // m0 wins tie
    vt[4]  = '{0, 0, 0, 1, 1, 0,    2'b01, 0,   0,   0, 0}; // m0 drops cyc
    vt[5]  = '{0, 0, 0, 1, 1, 1,    2'b10, 1,   1,   0, 1}; // direct handover
    vt[6]  = '{0, 1, 1, 1, 0, 1,    2'b10, 1,   0,   0, 1}; // no preemption
    vt[7]  = '{0, 1, 1, 0, 0, 1,    2'b10, 0,   0,   0, 1};
    vt[8]  = '{0, 1, 1, 0, 0, 1,    2'b01, 1,   1,   1, 0}; // back to waiting m0
    vt[9]  = '{0, 0, 0, 0, 0, 0,    2'b01, 0,   0,   0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 1,    2'b00, 0,   0,   0, 0}; // stray ack in idle
    vt[11] = '{0, 0, 0, 1, 1, 0,    2'b00, 0,   0,   0, 0};
    vt[12] = '{0, 0, 0, 1, 1, 0,    2'b10, 1,   1,   0, 0};
    vt[13] = '{1, 0, 0, 1, 1, 1,    2'b10, 1,   1,   0, 1}; // reset sampled at edge
    vt[14] = '{0, 0, 0, 1, 1, 1,    2'b00, 0,   0,   0, 0}; // ack discarded
    vt[15] = '{0, 0, 0, 1, 1, 0,    2'b10, 1,   1,   0, 0};
    vt[16] = '{0, 0, 0, 0, 0, 0,    2'b10, 0,   0,   0, 0};
    vt[17] = '{0, 0, 0, 0, 0, 0,    2'b00, 0,   0,   0, 0};

    m_cyc = '0; m_stb = '0; m_we = 2'b10;
    m_adr[0] = T_ADR0; m_dat[0] = T_DAT0; m_sel[0] = T_SEL0;
    m_adr[1] = T_ADR1; m_dat[1] = T_DAT1; m_sel[1] = T_SEL1;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // ------------------------------------------------------------ vectors
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      reset   = vt[i].rst;
      m_cyc   = {vt[i].c1, vt[i].c0};
      m_stb   = {vt[i].s1, vt[i].s0};
      tbl_ack = vt[i].sack;
      #1;
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
      if (vt[i].g == 2'b01) begin
        e_adr = T_ADR0; e_dat = T_DAT0; e_sel = T_SEL0; e_we = 1'b0;
      end else if (vt[i].g == 2'b10) begin
        e_adr = T_ADR1; e_dat = T_DAT1; e_sel = T_SEL1; e_we = 1'b1;
      end
      check($sformatf("vec%0d_grant", i),  32'(grant),  32'(vt[i].g));
      check($sformatf("vec%0d_s_cyc", i),  32'(s_cyc),  32'(vt[i].scyc));
      check($sformatf("vec%0d_s_stb", i),  32'(s_stb),  32'(vt[i].sstb));
      check($sformatf("vec%0d_m0_ack", i), 32'(m0_ack), 32'(vt[i].a0));
      check($sformatf("vec%0d_m1_ack", i), 32'(m1_ack), 32'(vt[i].a1));
      check($sformatf("vec%0d_s_adr", i),  s_adr,       e_adr);
      check($sformatf("vec%0d_s_datwr", i), s_datwr,    e_dat);
      check($sformatf("vec%0d_s_sel", i),  32'(s_sel),  32'(e_sel));
      check($sformatf("vec%0d_s_we", i),   32'(s_we),   32'(e_we));
    end

    // Hand the slave side to the SRAM model.
    m_cyc = '0; m_stb = '0; m_we = '0; tbl_ack = 1'b0;
    use_model = 1'b1;
    @(negedge clock);

    // ------------------------------------------------- single m1 write/read
    single_access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd);
    single_access(1, 1'b0, 32'h10, 32'h0, 4'hF, rd);
    check("m1_readback", rd, 32'hDEAD_BEEF);
    single_access(1, 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd);
    single_access(1, 1'b1, 32'h4, 32'h2222_2222, 4'hF, rd);
    single_access(1, 1'b1, 32'h8, 32'h3333_3333, 4'hF, rd);

    // ---------------------------------------------- burst hold by m0
    burst_exp[0] = 32'h1111_1111;
    burst_exp[1] = 32'h2222_2222;
    burst_exp[2] = 32'h3333_3333;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h0; m_sel[0] = 4'hF;
    idx = 0;
    for (k = 0; k < 40 && idx < 3; k++) begin
      if (k == 1) begin
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h10; m_sel[1] = 4'hF;
      end
      #1;
      if (k >= 1) check("burst_grant_m0", 32'(grant), 32'h1);
      check("burst_m1_ack", 32'(m1_ack), 32'd0);
      if (m0_ack) begin
        check($sformatf("burst_data%0d", idx), m0_datrd, burst_exp[idx]);
        idx++;
      end
      @(negedge clock);
      m_adr[0] = 32'(4 * idx);
    end
    check("burst_reads_done", 32'(idx), 32'd3);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    check("burst_release_cycle", 32'(grant), 32'h1);
    @(negedge clock);
    #1;
    check("burst_handover", 32'(grant), 32'h2);
    for (k = 0; k < 10; k++) begin
      if (m1_ack) break;
      @(negedge clock);
      #1;
    end
    check("burst_m1_ack_seen", 32'(m1_ack), 32'd1);
    check("burst_m1_data", m1_datrd, 32'hDEAD_BEEF);
    @(negedge clock);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(negedge clock);

    // ---------------------------------- both masters, 4 single writes each
    cnt[0] = 0; cnt[1] = 0; drop = '0; prev_g = 2'b00;
    for (k = 0; k < 200; k++) begin
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = (cnt[i] < 4) && !drop[i];
        m_stb[i] = (cnt[i] < 4) && !drop[i];
        m_we[i]  = 1'b1;
        m_sel[i] = 4'hF;
        m_adr[i] = ((i == 0) ? 32'h40 : 32'h80) + 32'(4 * cnt[i]);
        m_dat[i] = ((i == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(cnt[i]);
        drop[i]  = 1'b0;
      end
      #1;
      if (grant != prev_g && grant != 2'b00) glog.push_back(grant);
      prev_g = grant;
      for (int i = 0; i < 2; i++) begin
        if (acks[i]) begin
          check("alt_ack_owner", 32'(grant), 32'(own(i)));
          cnt[i]++;
          drop[i] = 1'b1;
        end
      end
      if (cnt[0] == 4 && cnt[1] == 4 && grant == 2'b00) break;
      @(negedge clock);
    end
    check("alt_m0_count", 32'(cnt[0]), 32'd4);
    check("alt_m1_count", 32'(cnt[1]), 32'd4);
    check("alt_grant_count", 32'(glog.size()), 32'd8);
    for (int j = 0; j < 8; j++)
      if (j < glog.size())
        check($sformatf("alt_grant%0d", j), 32'(glog[j]), (j % 2 == 0) ? 32'h1 : 32'h2);
    m_cyc = '0; m_stb = '0; m_we = '0;
    @(negedge clock);
    single_access(0, 1'b0, 32'h4C, 32'h0, 4'hF, rd);
    check("alt_m0_last_write", rd, 32'hA000_0003);
    single_access(1, 1'b0, 32'h80, 32'h0, 4'hF, rd);
    check("alt_m1_first_write", rd, 32'hB000_0000);

    // ----------------------------------------- simultaneous rise from IDLE
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_tie[0] = 2'b01; exp_tie[1] = 2'b10; exp_tie[2] = 2'b01; exp_tie[3] = 2'b10;
`else
    exp_tie[0] = 2'b01; exp_tie[1] = 2'b01; exp_tie[2] = 2'b01; exp_tie[3] = 2'b01;
`endif
    for (int r = 0; r < 4; r++) begin
      @(negedge clock);
      m_cyc = 2'b11; m_stb = 2'b00;
      #1;
      check($sformatf("tie%0d_idle", r), 32'(grant), 32'h0);
      @(negedge clock);
      m_cyc = 2'b00;
      #1;
      check($sformatf("tie%0d_winner", r), 32'(grant), 32'(exp_tie[r]));
      check($sformatf("tie%0d_acks", r), 32'(acks), 32'h0);
      @(negedge clock);
      #1;
      check($sformatf("tie%0d_release", r), 32'(grant), 32'h0);
    end

    // ---------------------------------------------- reset mid-access
    @(negedge clock);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h10;
    #1;
    check("rst_mid_idle", 32'(grant), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid_grant", 32'(grant), 32'h2);
    check("rst_mid_s_stb", 32'(s_stb), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    check("rst_mid_forced_idle", 32'(grant), 32'h0);
    check("rst_mid_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_mid_m0_ack", 32'(m0_ack), 32'd0);
    check("rst_mid_m1_ack", 32'(m1_ack), 32'd0);
    @(negedge clock);
    #1;
    check("rst_mid_stays_idle", 32'(grant), 32'h0);
    check("rst_mid_acks_after", 32'(acks), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
